seg7_scan_driver: RTL and testbench

- Consumes the divided scan and blink clocks from the clock-divider stage and drives the 4-digit seven-segment display.
- Both slow clocks are treated as asynchronous level signals: they are synchronized into the 100 MHz `clk` domain and edge-detected. They are never used as clocks.
- Time-multiplexes four 4-bit digit codes onto the shared segment bus, with per-digit blink, decimal point and global enable.

---
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_scan_driver.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between the display controller and seg7_scan_driver.
// The slave modport is the driver's view; master is the controller's.
interface seg7_scan_driver_if;
  logic        scan_clk;
  logic        blink_clk;
  logic        disp_en;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;

  modport master (
    output scan_clk, blink_clk, disp_en, digits, blink_mask, dp_mask,
    input  an, seg, dp, digit_idx
  );

  modport slave (
    input  scan_clk, blink_clk, disp_en, digits, blink_mask, dp_mask,
    output an, seg, dp, digit_idx
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Four-digit seven-segment scan driver; slow scan/blink clocks are synchronized and sampled as data.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN. SYNC_STAGES: 2..4.
module seg7_scan_driver #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input logic                clk,
  input logic                rst_n,
  seg7_scan_driver_if.slave  bus
);

  typedef enum logic [1:0] {Dig0, Dig1, Dig2, Dig3} idx_e;

  // Internal logic is active-low; this flips every output for active-high boards.
  localparam logic Inv = (SEG_ACTIVE_LOW == 0);

  localparam logic [3:0] AnOff  = {4{~Inv}};
  localparam logic [6:0] SegOff = {7{~Inv}};
  localparam logic       DpOff  = ~Inv;

  logic [SYNC_STAGES-1:0] scan_sync_q;
  logic [SYNC_STAGES-1:0] blink_sync_q;
  logic                   scan_dly_q;
  logic                   scan_sync;
  logic                   blink_sync;
  logic                   scan_tick;

  idx_e idx_q, idx_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [1:0] digit_idx_q;

  logic [1:0] cur;
  logic [3:0] code;
  logic [6:0] glyph;
  logic       lz_blank;
  logic       blank;
  logic [3:0] an_lo;
  logic [6:0] seg_lo;
  logic       dp_lo;

  assign scan_sync  = scan_sync_q[SYNC_STAGES-1];
  assign blink_sync = blink_sync_q[SYNC_STAGES-1];
  assign scan_tick  = scan_sync & ~scan_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_sync_q  <= '0;
      blink_sync_q <= '0;
      scan_dly_q   <= 1'b0;
    end else begin
      scan_sync_q  <= {scan_sync_q[SYNC_STAGES-2:0], bus.scan_clk};
      blink_sync_q <= {blink_sync_q[SYNC_STAGES-2:0], bus.blink_clk};
      scan_dly_q   <= scan_sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= Dig0;
    end else begin
      idx_q <= idx_d;
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (scan_tick) begin
      unique case (idx_q)
        Dig0:    idx_d = Dig1;
        Dig1:    idx_d = Dig2;
        Dig2:    idx_d = Dig3;
        Dig3:    idx_d = Dig0;
        default: idx_d = Dig0;
      endcase
    end
  end

  always_comb begin
    cur  = idx_q;
    code = bus.digits[{cur, 2'b00} +: 4];

    unique case (code)
      4'h0:    glyph = 7'h40;
      4'h1:    glyph = 7'h79;
      4'h2:    glyph = 7'h24;
      4'h3:    glyph = 7'h30;
      4'h4:    glyph = 7'h19;
      4'h5:    glyph = 7'h12;
      4'h6:    glyph = 7'h02;
      4'h7:    glyph = 7'h78;
      4'h8:    glyph = 7'h00;
      4'h9:    glyph = 7'h10;
      4'hA:    glyph = 7'h08;
      4'hB:    glyph = 7'h03;
      4'hC:    glyph = 7'h46;
      4'hD:    glyph = 7'h21;
      4'hE:    glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase

`ifdef SEG7_LZ_BLANK_EN
    unique case (cur)
      2'd3:    lz_blank = (bus.digits[15:12] == 4'h0);
      2'd2:    lz_blank = (bus.digits[15:8] == 8'h00);
      2'd1:    lz_blank = (bus.digits[15:4] == 12'h000);
      default: lz_blank = 1'b0;
    endcase
`else
    lz_blank = 1'b0;
`endif

    blank  = ~bus.disp_en | lz_blank | (bus.blink_mask[cur] & blink_sync);
    an_lo  = blank ? 4'hF : ~(4'b0001 << cur);
    seg_lo = blank ? 7'h7F : glyph;
    dp_lo  = blank ? 1'b1 : ~bus.dp_mask[cur];

    an_d  = an_lo ^ {4{Inv}};
    seg_d = seg_lo ^ {7{Inv}};
    dp_d  = dp_lo ^ Inv;
  end

  // Registered outputs keep anode switching glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q        <= AnOff;
      seg_q       <= SegOff;
      dp_q        <= DpOff;
      digit_idx_q <= 2'd0;
    end else begin
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      digit_idx_q <= idx_q;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (default parameters, active-low board).
module tb_seg7_scan_driver;

  logic clk;
  logic rst_n;
  int unsigned n_total;
  int unsigned n_pass;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .SYNC_STAGES    (2),
    .SEG_ACTIVE_LOW (1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_an(input int unsigned i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i[1:0]);
  endfunction

  task automatic scan_pulse();
    bus.scan_clk = 1'b1;
    repeat (4) step();
    bus.scan_clk = 1'b0;
    repeat (4) step();
  endtask

  // Raises scan_clk and checks the anode holds for 3 edges and moves on the 4th.
  task automatic scan_step_chk(input int unsigned nidx, input logic [6:0] nseg);
    bus.scan_clk = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      check("lat_hold_an", {12'h0, bus.an}, {12'h0, exp_an((nidx + 3) % 4)});
    end
    step();
    check("scan_an", {12'h0, bus.an}, {12'h0, exp_an(nidx)});
    check("scan_seg", {9'h0, bus.seg}, {9'h0, nseg});
    check("scan_idx", {14'h0, bus.digit_idx}, nidx[15:0]);
    bus.scan_clk = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    n_total        = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    bus.scan_clk   = 1'b0;
    bus.blink_clk  = 1'b0;
    bus.disp_en    = 1'b1;
    bus.digits     = 16'h8310;
    bus.blink_mask = 4'b0000;
    bus.dp_mask    = 4'b0000;

    // 1. Reset with scan_clk toggling
    repeat (6) begin
      step();
      bus.scan_clk = ~bus.scan_clk;
    end
    check("rst_an", {12'h0, bus.an}, 16'h000F);
    check("rst_seg", {9'h0, bus.seg}, 16'h007F);
    check("rst_dp", {15'h0, bus.dp}, 16'h0001);
    check("rst_idx", {14'h0, bus.digit_idx}, 16'h0000);
    bus.scan_clk = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_an", {12'h0, bus.an}, 16'h000E);
    check("post_rst_seg", {9'h0, bus.seg}, 16'h0040);
    check("post_rst_dp", {15'h0, bus.dp}, 16'h0001);
    repeat (3) step();

    // 2. Scan order and 4-edge latency, digits 8310
    scan_step_chk(1, 7'h79);
    scan_step_chk(2, 7'h30);
    scan_step_chk(3, 7'h00);
    scan_step_chk(0, 7'h40);

    // 3. Blink on digit 1
    scan_pulse();
    bus.blink_mask = 4'b0010;
    bus.blink_clk  = 1'b1;
    repeat (5) step();
    check("blink_on_an", {12'h0, bus.an}, 16'h000F);
    check("blink_on_seg", {9'h0, bus.seg}, 16'h007F);
    check("blink_on_idx", {14'h0, bus.digit_idx}, 16'h0001);
    bus.blink_clk = 1'b0;
    repeat (5) step();
    check("blink_off_an", {12'h0, bus.an}, 16'h000D);
    check("blink_off_seg", {9'h0, bus.seg}, 16'h0079);

    // 4. Decimal point on digit 2 only, then global disable
    bus.blink_mask = 4'b0000;
    bus.dp_mask    = 4'b0100;
    step();
    check("dp_idx1", {15'h0, bus.dp}, 16'h0001);
    scan_pulse();
    check("dp_idx2", {15'h0, bus.dp}, 16'h0000);
    check("dp_idx2_an", {12'h0, bus.an}, 16'h000B);
    scan_pulse();
    check("dp_idx3", {15'h0, bus.dp}, 16'h0001);
    bus.disp_en = 1'b0;
    step();
    check("dis_an", {12'h0, bus.an}, 16'h000F);
    check("dis_seg", {9'h0, bus.seg}, 16'h007F);
    scan_pulse();
    check("dis_idx_adv", {14'h0, bus.digit_idx}, 16'h0000);
    check("dis_an_hold", {12'h0, bus.an}, 16'h000F);
    bus.disp_en = 1'b1;
    step();
    check("en_an", {12'h0, bus.an}, 16'h000E);

    // 5. Hex F everywhere and wrap over 9 ticks
    bus.dp_mask = 4'b0000;
    bus.digits  = 16'hFFFF;
    step();
    check("hex_seg_live", {9'h0, bus.seg}, 16'h000E);
    for (int k = 1; k <= 9; k++) begin
      scan_pulse();
      check("wrap_idx", {14'h0, bus.digit_idx}, 16'(k % 4));
      check("wrap_an", {12'h0, bus.an}, {12'h0, exp_an(k % 4)});
      check("wrap_seg", {9'h0, bus.seg}, 16'h000E);
    end

    // 6. Leading zeros, digits 0050; idx is 1 after 9 ticks from 0
    bus.digits = 16'h0050;
    step();
    check("lz_d1_an", {12'h0, bus.an}, 16'h000D);
    check("lz_d1_seg", {9'h0, bus.seg}, 16'h0012);
    scan_pulse();
`ifdef SEG7_LZ_BLANK_EN
    check("lz_d2_an", {12'h0, bus.an}, 16'h000F);
`else
    check("lz_d2_an", {12'h0, bus.an}, 16'h000B);
    check("lz_d2_seg", {9'h0, bus.seg}, 16'h0040);
`endif
    scan_pulse();
`ifdef SEG7_LZ_BLANK_EN
    check("lz_d3_an", {12'h0, bus.an}, 16'h000F);
`else
    check("lz_d3_an", {12'h0, bus.an}, 16'h0007);
`endif
    scan_pulse();
    check("lz_d0_an", {12'h0, bus.an}, 16'h000E);
    check("lz_d0_seg", {9'h0, bus.seg}, 16'h0040);

    // Reset mid-scan is immediate; move to idx 2 first
    scan_pulse();
    scan_pulse();
    check("pre_rst_idx", {14'h0, bus.digit_idx}, 16'h0002);
    rst_n = 1'b0;
    #1;
    check("async_rst_an", {12'h0, bus.an}, 16'h000F);
    check("async_rst_seg", {9'h0, bus.seg}, 16'h007F);
    check("async_rst_idx", {14'h0, bus.digit_idx}, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    check("rerun_an", {12'h0, bus.an}, 16'h000E);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
